// File: rtl/router_pkg.sv
// Shared types for the N-port router control FSM: one-hot state encoding,
// decoded-output bundle and default sizing constants.
package router_pkg;

    localparam int NUM_PORTS_DEF      = 3;
    localparam int TIMEOUT_CYCLES_DEF = 64;
    localparam int STATE_W            = 9;

    typedef enum logic [STATE_W-1:0] {
        DECODE_ADDRESS     = 9'b0_0000_0001,
        WAIT_TILL_EMPTY    = 9'b0_0000_0010,
        LOAD_FIRST_DATA    = 9'b0_0000_0100,
        LOAD_DATA          = 9'b0_0000_1000,
        FIFO_FULL_STATE    = 9'b0_0001_0000,
        LOAD_AFTER_FULL    = 9'b0_0010_0000,
        LOAD_PARITY        = 9'b0_0100_0000,
        CHECK_PARITY_ERROR = 9'b0_1000_0000,
        DROP_PKT           = 9'b1_0000_0000
    } state_t;

    typedef struct packed {
        logic busy;
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic write_enb_reg;
        logic rst_int_reg;
        logic drop_state;
    } fsm_out_t;

    function automatic fsm_out_t state_decode(input state_t s);
        fsm_out_t o;
        o = '0;
        case (s)
            DECODE_ADDRESS:     o.detect_add = 1'b1;
            WAIT_TILL_EMPTY:    o.busy = 1'b1;
            LOAD_FIRST_DATA:    begin o.busy = 1'b1; o.lfd_state = 1'b1; end
            LOAD_DATA:          begin o.ld_state = 1'b1; o.write_enb_reg = 1'b1; end
            FIFO_FULL_STATE:    begin o.busy = 1'b1; o.full_state = 1'b1; end
            LOAD_AFTER_FULL:    begin o.busy = 1'b1; o.laf_state = 1'b1; o.write_enb_reg = 1'b1; end
            LOAD_PARITY:        begin o.busy = 1'b1; o.write_enb_reg = 1'b1; end
            CHECK_PARITY_ERROR: begin o.busy = 1'b1; o.rst_int_reg = 1'b1; end
            DROP_PKT:           o.drop_state = 1'b1;
            default:            o.detect_add = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Wait-for-empty timer: counts cycles spent waiting and flags the terminal
// cycle. Only present when ROUTER_FSM_WAIT_TIMEOUT_EN is defined.
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
module router_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic resetn,
    input  logic run_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Counter restarts from zero every time the wait state is (re)entered.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (run_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign tc_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/router_fsm_nport.sv
// Router control FSM for NUM_PORTS output channels with Moore state decodes.
// Optional wait-for-empty timeout enabled by ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm_nport
    import router_pkg::*;
#(
    parameter int NUM_PORTS      = NUM_PORTS_DEF,
    parameter int ADDR_W         = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic                 parity_done,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 fifo_full,
    input  logic                 low_pkt_valid,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [ADDR_W-1:0]    data_in,
    output logic                 busy,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 drop_state,
    output logic                 timeout_err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    fsm_out_t          out_q;
    logic              timeout_q, timeout_d;

    logic soft_sel_s;
    logic empty_sel_s;
    logic empty_din_s;
    logic din_in_range_s;
    logic in_wait_s;
    logic tc_s;

    assign in_wait_s = (state_q == WAIT_TILL_EMPTY);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    router_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock  (clock),
        .resetn (resetn),
        .run_i  (in_wait_s),
        .tc_o   (tc_s)
    );
`else
    assign tc_s = 1'b0;
`endif

    // Channel selects; out-of-range addresses match no channel.
    always_comb begin
        soft_sel_s     = 1'b0;
        empty_sel_s    = 1'b0;
        empty_din_s    = 1'b0;
        din_in_range_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            soft_sel_s     = (addr_q  == ADDR_W'(i)) ? soft_reset[i] : soft_sel_s;
            empty_sel_s    = (addr_q  == ADDR_W'(i)) ? fifo_empty[i] : empty_sel_s;
            empty_din_s    = (data_in == ADDR_W'(i)) ? fifo_empty[i] : empty_din_s;
            din_in_range_s = din_in_range_s | (data_in == ADDR_W'(i));
        end
    end

    // Next-state logic: channel soft reset, then timeout, then normal flow.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        timeout_d = 1'b0;
        if ((state_q != DECODE_ADDRESS) && soft_sel_s) begin
            state_d = DECODE_ADDRESS;
        end else if (tc_s && !empty_sel_s) begin
            state_d   = DROP_PKT;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (pkt_valid) begin
                        addr_d = data_in;
                        if (!din_in_range_s) begin
                            state_d = DROP_PKT;
                        end else if (empty_din_s) begin
                            state_d = LOAD_FIRST_DATA;
                        end else begin
                            state_d = WAIT_TILL_EMPTY;
                        end
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_sel_s) begin
                        state_d = LOAD_FIRST_DATA;
                    end else begin
                        state_d = WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        state_d = LOAD_AFTER_FULL;
                    end else begin
                        state_d = FIFO_FULL_STATE;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                DROP_PKT: begin
                    if (!pkt_valid) begin
                        state_d = DECODE_ADDRESS;
                    end else begin
                        state_d = DROP_PKT;
                    end
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    // State, latched address and output decodes registered together so the
    // decodes track the current state with no extra latency.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= DECODE_ADDRESS;
            addr_q    <= '0;
            out_q     <= state_decode(DECODE_ADDRESS);
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            out_q     <= state_decode(state_d);
            timeout_q <= timeout_d;
        end
    end

    assign busy          = out_q.busy;
    assign detect_add    = out_q.detect_add;
    assign lfd_state     = out_q.lfd_state;
    assign ld_state      = out_q.ld_state;
    assign laf_state     = out_q.laf_state;
    assign full_state    = out_q.full_state;
    assign write_enb_reg = out_q.write_enb_reg;
    assign rst_int_reg   = out_q.rst_int_reg;
    assign drop_state    = out_q.drop_state;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_router_fsm_nport.sv
// Directed self-checking bench for router_fsm_nport (NUM_PORTS=3, TIMEOUT_CYCLES=8);
// the timeout scenario follows ROUTER_FSM_WAIT_TIMEOUT_EN.
module tb_router_fsm_nport;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic       parity_done;
    logic [2:0] soft_reset;
    logic       fifo_full;
    logic       low_pkt_valid;
    logic [2:0] fifo_empty;
    logic [1:0] data_in;
    logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, drop_state, timeout_err;

    int tests  = 0;
    int failed = 0;

    // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int, drop, timeout_err}
    localparam logic [9:0] E_DA   = 10'b0100000000;
    localparam logic [9:0] E_WTE  = 10'b1000000000;
    localparam logic [9:0] E_LFD  = 10'b1010000000;
    localparam logic [9:0] E_LD   = 10'b0001001000;
    localparam logic [9:0] E_FFS  = 10'b1000010000;
    localparam logic [9:0] E_LAF  = 10'b1000101000;
    localparam logic [9:0] E_LP   = 10'b1000001000;
    localparam logic [9:0] E_CPE  = 10'b1000000100;
    localparam logic [9:0] E_DROP = 10'b0000000010;
    localparam logic [9:0] E_DROP_TO = 10'b0000000011;

    router_fsm_nport #(
        .NUM_PORTS      (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .parity_done   (parity_done),
        .soft_reset    (soft_reset),
        .fifo_full     (fifo_full),
        .low_pkt_valid (low_pkt_valid),
        .fifo_empty    (fifo_empty),
        .data_in       (data_in),
        .busy          (busy),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .drop_state    (drop_state),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    function automatic logic [9:0] obs();
        return {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, drop_state, timeout_err};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid = 1'b0; parity_done = 1'b0; soft_reset = 3'b000; fifo_full = 1'b0;
        low_pkt_valid = 1'b0; fifo_empty = 3'b000; data_in = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (obs() !== E_DA) begin
            failed++; $display("FAIL reset_outputs: got %b expected %b", obs(), E_DA);
        end
        step();
        tests++;
        if (obs() !== E_DA) begin
            failed++; $display("FAIL reset_idle: got %b expected %b", obs(), E_DA);
        end
    endtask

    task automatic test_normal_packet();
        logic [9:0] exp_seq [5] = '{E_LFD, E_LD, E_LP, E_CPE, E_DA};
        do_reset();
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b010;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) pkt_valid = 1'b0;
            tests++;
            if (obs() !== exp_seq[i]) begin
                failed++; $display("FAIL normal_pkt[%0d]: got %b expected %b", i, obs(), exp_seq[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [9:0] exp_seq [8] = '{E_LFD, E_LD, E_FFS, E_FFS, E_LAF, E_LP, E_CPE, E_DA};
        do_reset();
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b100;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 1) fifo_full = 1'b1;
            if (i == 3) begin fifo_full = 1'b0; low_pkt_valid = 1'b1; end
            if (i == 5) begin pkt_valid = 1'b0; low_pkt_valid = 1'b0; end
            tests++;
            if (obs() !== exp_seq[i]) begin
                failed++; $display("FAIL fifo_full[%0d]: got %b expected %b", i, obs(), exp_seq[i]);
            end
        end
    endtask

    task automatic test_full_variants();
        logic [9:0] exp_seq [9] = '{E_LFD, E_LD, E_FFS, E_LAF, E_LD, E_LP, E_CPE, E_FFS, E_LAF};
        do_reset();
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b001;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 1) begin fifo_full = 1'b1; pkt_valid = 1'b0; end
            if (i == 2) fifo_full = 1'b0;
            if (i == 5) fifo_full = 1'b1;
            if (i == 7) fifo_full = 1'b0;
            if (i == 8) parity_done = 1'b1;
            tests++;
            if (obs() !== exp_seq[i]) begin
                failed++; $display("FAIL full_variants[%0d]: got %b expected %b", i, obs(), exp_seq[i]);
            end
        end
        step();
        parity_done = 1'b0;
        tests++;
        if (obs() !== E_DA) begin
            failed++; $display("FAIL laf_parity_done: got %b expected %b", obs(), E_DA);
        end
    endtask

    task automatic test_drop();
        do_reset();
        pkt_valid = 1'b1; data_in = 2'b11; fifo_empty = 3'b111;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 4) pkt_valid = 1'b0;
            tests++;
            if (obs() !== E_DROP) begin
                failed++; $display("FAIL drop[%0d]: got %b expected %b", i, obs(), E_DROP);
            end
        end
        step();
        tests++;
        if (obs() !== E_DA) begin
            failed++; $display("FAIL drop_exit: got %b expected %b", obs(), E_DA);
        end
    endtask

    task automatic test_soft_reset();
        do_reset();
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b000;
        step();
        pkt_valid = 1'b0;
        tests++;
        if (obs() !== E_WTE) begin
            failed++; $display("FAIL soft_wait_entry: got %b expected %b", obs(), E_WTE);
        end
        soft_reset = 3'b010;
        step();
        tests++;
        if (obs() !== E_WTE) begin
            failed++; $display("FAIL soft_other_ch: got %b expected %b", obs(), E_WTE);
        end
        soft_reset = 3'b001;
        step();
        soft_reset = 3'b000;
        tests++;
        if (obs() !== E_DA) begin
            failed++; $display("FAIL soft_own_ch: got %b expected %b", obs(), E_DA);
        end
        // soft reset while loading data
        pkt_valid = 1'b1; fifo_empty = 3'b001;
        step(); step();
        soft_reset = 3'b001;
        tests++;
        if (obs() !== E_LD) begin
            failed++; $display("FAIL soft_ld_setup: got %b expected %b", obs(), E_LD);
        end
        step();
        soft_reset = 3'b000; pkt_valid = 1'b0;
        tests++;
        if (obs() !== E_DA) begin
            failed++; $display("FAIL soft_in_ld: got %b expected %b", obs(), E_DA);
        end
    endtask

    task automatic test_wait_release();
        do_reset();
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
        step();
        pkt_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (obs() !== E_WTE) begin
                failed++; $display("FAIL wait_hold[%0d]: got %b expected %b", i, obs(), E_WTE);
            end
            step();
        end
        // seventh wait cycle now showing; release before any timeout
        fifo_empty = 3'b010;
        step();
        tests++;
        if (obs() !== E_LFD) begin
            failed++; $display("FAIL wait_release: got %b expected %b", obs(), E_LFD);
        end
    endtask

    task automatic test_timeout();
        int wait_cnt;
        int pulses;
        do_reset();
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b000;
        step();
        pkt_valid = 1'b0;
        wait_cnt = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (obs() === E_WTE) wait_cnt++;
            if (timeout_err === 1'b1) pulses++;
            step();
        end
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        tests++;
        if (wait_cnt !== 8) begin
            failed++; $display("FAIL timeout_wait_cycles: got %0d expected 8", wait_cnt);
        end
        tests++;
        if (pulses !== 1) begin
            failed++; $display("FAIL timeout_pulses: got %0d expected 1", pulses);
        end
        // pulse must coincide with the first drop cycle
        do_reset();
        pkt_valid = 1'b1; data_in = 2'd1;
        step();
        pkt_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        tests++;
        if (obs() !== E_DROP_TO) begin
            failed++; $display("FAIL timeout_drop: got %b expected %b", obs(), E_DROP_TO);
        end
        step();
        tests++;
        if (obs() !== E_DA) begin
            failed++; $display("FAIL timeout_exit: got %b expected %b", obs(), E_DA);
        end
        // empty rising in the terminal cycle beats the timeout
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        fifo_empty = 3'b010;
        step();
        tests++;
        if (obs() !== E_LFD) begin
            failed++; $display("FAIL timeout_race: got %b expected %b", obs(), E_LFD);
        end
`else
        tests++;
        if (wait_cnt !== 20) begin
            failed++; $display("FAIL wait_forever_cycles: got %0d expected 20", wait_cnt);
        end
        tests++;
        if (pulses !== 0) begin
            failed++; $display("FAIL wait_forever_pulses: got %0d expected 0", pulses);
        end
`endif
    endtask

    task automatic test_reset_in_full();
        do_reset();
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b100;
        step(); step();
        fifo_full = 1'b1;
        step();
        tests++;
        if (obs() !== E_FFS) begin
            failed++; $display("FAIL rst_full_setup: got %b expected %b", obs(), E_FFS);
        end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        idle_inputs();
        tests++;
        if (obs() !== E_DA) begin
            failed++; $display("FAIL rst_in_full: got %b expected %b", obs(), E_DA);
        end
        step();
        tests++;
        if (obs() !== E_DA) begin
            failed++; $display("FAIL rst_no_write: got %b expected %b", obs(), E_DA);
        end
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        test_reset();
        test_normal_packet();
        test_fifo_full();
        test_full_variants();
        test_drop();
        test_soft_reset();
        test_wait_release();
        test_timeout();
        test_reset_in_full();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
